// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by fetch, the instruction buffer and decode.
package cpu_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ibuf_entry_t;

endpackage

// File: rtl/instr_buffer_if.sv
// Fetch-side and decode-side valid/ready handshake bundle of the instruction buffer.
interface instr_buffer_if;
  import cpu_pkg::*;

  logic            fetch_i_valid;
  logic [XLEN-1:0] fetch_i_pc;
  logic [ILEN-1:0] fetch_i_instr;
  logic            ibuf_o_ready;
  logic            decode_i_ready;
  logic            ibuf_o_valid;
  logic [XLEN-1:0] ibuf_o_pc;
  logic [ILEN-1:0] ibuf_o_instr;

  modport master (
    output fetch_i_valid, fetch_i_pc, fetch_i_instr, decode_i_ready,
    input  ibuf_o_ready, ibuf_o_valid, ibuf_o_pc, ibuf_o_instr
  );

  modport slave (
    input  fetch_i_valid, fetch_i_pc, fetch_i_instr, decode_i_ready,
    output ibuf_o_ready, ibuf_o_valid, ibuf_o_pc, ibuf_o_instr
  );

endinterface

// File: rtl/instr_buffer_ptr.sv
// Circular-buffer pointer with a wrap bit above the index bits; clear wins over increment.
module ibuf_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_inc,
  input  logic                   i_clr,
  output logic [$clog2(DEPTH):0] o_ptr
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_next;

  // DEPTH is a power of two, so plain binary increment rolls the index and toggles the wrap bit.
  always_comb begin
    w_ptr_next = r_ptr;
    if (i_clr) begin
      w_ptr_next = '0;
    end else if (i_inc) begin
      w_ptr_next = r_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/instr_buffer.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer of {pc, instr} with flush.
module instr_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_buffer_if.slave          bus,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] ibuf_o_count,
  output logic                   ibuf_o_full,
  output logic                   ibuf_o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  ibuf_entry_t   r_mem [DEPTH];
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_en;
  ibuf_entry_t   w_head;

  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[AW-1:0] == w_rd_ptr[AW-1:0]) && (w_wr_ptr[AW] != w_rd_ptr[AW]);

  // Ready comes from registered state only, so a full buffer refuses a push even if decode pops.
  assign bus.ibuf_o_ready = ~rst & ~w_full;
  assign w_push           = bus.fetch_i_valid & bus.ibuf_o_ready;
  assign w_pop            = ~w_empty & bus.decode_i_ready;
  assign w_wr_en          = w_push & ~flush_i;

  ibuf_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push),
    .i_clr (flush_i),
    .o_ptr (w_wr_ptr)
  );

  ibuf_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop),
    .i_clr (flush_i),
    .o_ptr (w_rd_ptr)
  );

  // Storage is deliberately unreset; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_ptr[AW-1:0]] <= '{pc: bus.fetch_i_pc, instr: bus.fetch_i_instr};
    end
  end

  always_comb begin
    w_head           = r_mem[w_rd_ptr[AW-1:0]];
    bus.ibuf_o_valid = ~w_empty;
    bus.ibuf_o_pc    = w_empty ? '0 : w_head.pc;
    bus.ibuf_o_instr = w_empty ? NOP_INSTR : w_head.instr;
  end

  assign ibuf_o_count = w_wr_ptr - w_rd_ptr;
  assign ibuf_o_full  = w_full;
  assign ibuf_o_empty = w_empty;

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer (DEPTH=4): vector table plus reset, wrap-stream and async-reset
module tb_instr_buffer;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  logic       flush_i;
  logic [2:0] ibuf_o_count;
  logic       ibuf_o_full;
  logic       ibuf_o_empty;

  int n_cmp;
  int n_err;

  instr_buffer_if bus ();

  instr_buffer #(
    .DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .flush_i      (flush_i),
    .ibuf_o_count (ibuf_o_count),
    .ibuf_o_full  (ibuf_o_full),
    .ibuf_o_empty (ibuf_o_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        dr;
    logic        fl;
    logic        e_rdy;
    logic        e_vld;
    logic [63:0] e_pc;
    logic [31:0] e_ins;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic fv, logic [63:0] pc, logic [31:0] ins, logic dr, logic fl,
                              logic e_rdy, logic e_vld, logic [63:0] e_pc, logic [31:0] e_ins,
                              logic [2:0] e_cnt, logic e_full, logic e_empty);
    vec_t v;
    v.fv = fv; v.pc = pc; v.ins = ins; v.dr = dr; v.fl = fl;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_pc = e_pc; v.e_ins = e_ins;
    v.e_cnt = e_cnt; v.e_full = e_full; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_i_valid  = 1'b0;
    bus.fetch_i_pc     = '0;
    bus.fetch_i_instr  = '0;
    bus.decode_i_ready = 1'b0;
    flush_i            = 1'b0;
  endtask

  task automatic chk_empty_state(input string tag, input logic exp_rdy);
    chk({tag, "_rdy"}, 64'(bus.ibuf_o_ready), 64'(exp_rdy));
    chk({tag, "_vld"}, 64'(bus.ibuf_o_valid), 64'd0);
    chk({tag, "_pc"}, bus.ibuf_o_pc, 64'd0);
    chk({tag, "_ins"}, 64'(bus.ibuf_o_instr), 64'h13);
    chk({tag, "_cnt"}, 64'(ibuf_o_count), 64'd0);
    chk({tag, "_empty"}, 64'(ibuf_o_empty), 64'd1);
    chk({tag, "_full"}, 64'(ibuf_o_full), 64'd0);
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    int sent;
    int recv;
    int cyc;
    logic [63:0] exp_pc;

    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();

    // 1 = push only, refused push while full, drain across the wrap, flush with push+pop.
    vecs[0]  = mk(1, 64'h8000_0000, 32'h1111_1111, 0, 0, 1, 0, 64'h0, NOP, 0, 0, 1);
    vecs[1]  = mk(1, 64'h8000_0004, 32'h2222_2222, 0, 0, 1, 1, 64'h8000_0000, 32'h1111_1111,
                  1, 0, 0);
    vecs[2]  = mk(1, 64'h8000_0008, 32'h3333_3333, 0, 0, 1, 1, 64'h8000_0000, 32'h1111_1111,
                  2, 0, 0);
    vecs[3]  = mk(1, 64'h8000_000C, 32'h4444_4444, 0, 0, 1, 1, 64'h8000_0000, 32'h1111_1111,
                  3, 0, 0);
    vecs[4]  = mk(1, 64'h8000_0010, 32'h5555_5555, 1, 0, 0, 1, 64'h8000_0000, 32'h1111_1111,
                  4, 1, 0);
    vecs[5]  = mk(1, 64'h8000_0010, 32'h5555_5555, 0, 0, 1, 1, 64'h8000_0004, 32'h2222_2222,
                  3, 0, 0);
    vecs[6]  = mk(0, 64'h0, 32'h0, 0, 0, 0, 1, 64'h8000_0004, 32'h2222_2222, 4, 1, 0);
    vecs[7]  = mk(0, 64'h0, 32'h0, 1, 0, 0, 1, 64'h8000_0004, 32'h2222_2222, 4, 1, 0);
    vecs[8]  = mk(0, 64'h0, 32'h0, 1, 0, 1, 1, 64'h8000_0008, 32'h3333_3333, 3, 0, 0);
    vecs[9]  = mk(0, 64'h0, 32'h0, 1, 0, 1, 1, 64'h8000_000C, 32'h4444_4444, 2, 0, 0);
    vecs[10] = mk(0, 64'h0, 32'h0, 1, 0, 1, 1, 64'h8000_0010, 32'h5555_5555, 1, 0, 0);
    vecs[11] = mk(0, 64'h0, 32'h0, 0, 0, 1, 0, 64'h0, NOP, 0, 0, 1);
    vecs[12] = mk(1, 64'h9000_0000, 32'h6666_6666, 0, 0, 1, 0, 64'h0, NOP, 0, 0, 1);
    vecs[13] = mk(1, 64'h9000_0004, 32'h7777_7777, 0, 0, 1, 1, 64'h9000_0000, 32'h6666_6666,
                  1, 0, 0);
    vecs[14] = mk(1, 64'h9000_0008, 32'h8888_8888, 0, 0, 1, 1, 64'h9000_0000, 32'h6666_6666,
                  2, 0, 0);
    vecs[15] = mk(1, 64'h9000_000C, 32'h9999_9999, 1, 1, 1, 1, 64'h9000_0000, 32'h6666_6666,
                  3, 0, 0);
    vecs[16] = mk(0, 64'h0, 32'h0, 0, 0, 1, 0, 64'h0, NOP, 0, 0, 1);

    // Reset held for three edges, then released.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_empty_state($sformatf("rst%0d", i), 1'b0);
    end
    rst = 1'b0;
    #1;
    chk_empty_state("post_rst", 1'b1);

    for (int i = 0; i < 17; i++) begin
      step();
      bus.fetch_i_valid  = vecs[i].fv;
      bus.fetch_i_pc     = vecs[i].pc;
      bus.fetch_i_instr  = vecs[i].ins;
      bus.decode_i_ready = vecs[i].dr;
      flush_i            = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_rdy", i), 64'(bus.ibuf_o_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_vld", i), 64'(bus.ibuf_o_valid), 64'(vecs[i].e_vld));
      chk($sformatf("v%0d_pc", i), bus.ibuf_o_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_ins", i), 64'(bus.ibuf_o_instr), 64'(vecs[i].e_ins));
      chk($sformatf("v%0d_cnt", i), 64'(ibuf_o_count), 64'(vecs[i].e_cnt));
      chk($sformatf("v%0d_full", i), 64'(ibuf_o_full), 64'(vecs[i].e_full));
      chk($sformatf("v%0d_empty", i), 64'(ibuf_o_empty), 64'(vecs[i].e_empty));
    end

    // Stream 10 entries with decode ready toggling 1,0,1,0; check order across the wrap.
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 10 && cyc < 200) begin
      step();
      bus.fetch_i_valid  = (sent < 10);
      bus.fetch_i_pc     = 64'h8000_0000 + 64'(4 * sent);
      bus.fetch_i_instr  = 32'hC0DE_0000 | 32'(sent);
      bus.decode_i_ready = (cyc % 2 == 0);
      flush_i            = 1'b0;
      #1;
      if (bus.ibuf_o_valid && bus.decode_i_ready) begin
        exp_pc = 64'h8000_0000 + 64'(4 * recv);
        chk($sformatf("strm%0d_pc", recv), bus.ibuf_o_pc, exp_pc);
        chk($sformatf("strm%0d_ins", recv), 64'(bus.ibuf_o_instr),
            64'(32'hC0DE_0000 | 32'(recv)));
        recv++;
      end
      if (bus.fetch_i_valid && bus.ibuf_o_ready) sent++;
      cyc++;
    end
    chk("strm_recv_total", 64'(recv), 64'd10);
    step();
    idle_inputs();
    #1;
    chk("strm_drained_empty", 64'(ibuf_o_empty), 64'd1);

    // Two entries, then reset asserted between edges must empty the buffer immediately.
    bus.fetch_i_valid = 1'b1;
    bus.fetch_i_pc    = 64'hA000_0000;
    bus.fetch_i_instr = 32'hAAAA_0001;
    step();
    bus.fetch_i_pc    = 64'hA000_0004;
    bus.fetch_i_instr = 32'hAAAA_0002;
    step();
    bus.fetch_i_valid = 1'b0;
    #1;
    chk("arst_pre_cnt", 64'(ibuf_o_count), 64'd2);
    chk("arst_pre_pc", bus.ibuf_o_pc, 64'hA000_0000);
    #1;
    rst = 1'b1;
    #1;
    chk_empty_state("arst", 1'b0);
    step();
    rst = 1'b0;
    #1;
    chk_empty_state("arst_rel", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
